// File: rtl/chord_sched_pkg.sv
// Shared definitions for the chord scheduler: song ROM entry layout,
// end marker and FSM state encoding.
package chord_sched_pkg;

  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int META_MSB = 2;
  localparam int META_LSB = 0;
  localparam int ADV_BIT  = 15;

  localparam logic [15:0] END_MARKER = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ROM_WAIT  = 3'd2,
    S_DECODE    = 3'd3,
    S_LOAD      = 3'd4,
    S_GUARD     = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_SONG_DONE = 3'd7
  } state_e;

  function automatic logic [5:0] entry_note(input logic [15:0] e);
    return e[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [2:0] entry_meta(input logic [15:0] e);
    return e[META_MSB:META_LSB];
  endfunction

  function automatic logic [5:0] entry_dur(input logic [15:0] e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/chord_scheduler_if.sv
// Song ROM bus and notes-player load bus of the chord scheduler.
interface chord_scheduler_if #(
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic [5:0]            note1;
  logic [5:0]            note2;
  logic [5:0]            note3;
  logic [5:0]            note4;
  logic [2:0]            metadata1;
  logic [2:0]            metadata2;
  logic [2:0]            metadata3;
  logic [2:0]            metadata4;
  logic [1:0]            num_notes;
  logic [5:0]            duration;
  logic                  load_new_note;
  logic                  play_enable;
  logic                  done_with_note;

  modport master (
    output rom_addr, note1, note2, note3, note4,
    output metadata1, metadata2, metadata3, metadata4,
    output num_notes, duration, load_new_note, play_enable,
    input  rom_data, done_with_note
  );

  modport slave (
    input  rom_addr, note1, note2, note3, note4,
    input  metadata1, metadata2, metadata3, metadata4,
    input  num_notes, duration, load_new_note, play_enable,
    output rom_data, done_with_note
  );
endinterface

// File: rtl/chord_scheduler_accumulator.sv
// Collects up to four note entries into chord slots; writes beyond the
// fourth are dropped. num_notes is registered as voice count minus one.
module chord_accumulator (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr,
  input  logic [5:0]      note,
  input  logic [2:0]      meta,
  output logic [3:0][5:0] notes_q,
  output logic [3:0][2:0] metas_q,
  output logic [1:0]      num_notes_q
);
  logic [2:0]      count_q;
  logic [2:0]      count_d;
  logic [3:0][5:0] notes_d;
  logic [3:0][2:0] metas_d;
  logic [1:0]      num_notes_d;

  // Slot fill / clear; clear wins over a simultaneous write
  always_comb begin
    count_d = count_q;
    notes_d = notes_q;
    metas_d = metas_q;
    if (clear) begin
      count_d = 3'd0;
      notes_d = {4{6'd0}};
      metas_d = {4{3'd0}};
    end else if (wr && (count_q < 3'd4)) begin
      notes_d[count_q[1:0]] = note;
      metas_d[count_q[1:0]] = meta;
      count_d               = count_q + 3'd1;
    end else begin
      count_d = count_q;
    end
    // count 1..4 maps to 0..3 via the low two bits minus one; empty is a rest
    if (count_d == 3'd0) begin
      num_notes_d = 2'd0;
    end else begin
      num_notes_d = count_d[1:0] - 2'd1;
    end
  end

  // Slot state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= 3'd0;
      notes_q     <= {4{6'd0}};
      metas_q     <= {4{3'd0}};
      num_notes_q <= 2'd0;
    end else begin
      count_q     <= count_d;
      notes_q     <= notes_d;
      metas_q     <= metas_d;
      num_notes_q <= num_notes_d;
    end
  end

endmodule

// File: rtl/chord_scheduler.sv
// Song sequencer: fetches ROM entries, builds chords and hands them to the
// notes player. Define LOOP_EN to loop the song instead of stopping at its end.
module chord_scheduler
  import chord_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 7,
  parameter int SONG_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [SONG_SEL_WIDTH-1:0] song_sel,
  input  logic                      restart,
  output logic                      song_done,
  chord_scheduler_if.master         sif
);
  localparam int OFS_W = ADDR_WIDTH - SONG_SEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [5:0]            dur_q, dur_d;
  logic                  load_q, load_d;
  logic                  play_enable_q, play_enable_d;
  logic                  song_done_q, song_done_d;
  logic                  play_prev_q;
  logic                  acc_clr_s, acc_wr_s, end_hit_s, last_s;
  logic [ADDR_WIDTH-1:0] sel_base_s;
  logic [3:0][5:0]       notes_s;
  logic [3:0][2:0]       metas_s;
  logic [1:0]            num_notes_s;

  assign sel_base_s = {song_sel, {OFS_W{1'b0}}};
  assign last_s     = &addr_q[OFS_W-1:0];

  chord_accumulator u_acc (
    .clk         (clk),
    .reset       (reset),
    .clear       (acc_clr_s),
    .wr          (acc_wr_s),
    .note        (entry_note(sif.rom_data)),
    .meta        (entry_meta(sif.rom_data)),
    .notes_q     (notes_s),
    .metas_q     (metas_s),
    .num_notes_q (num_notes_s)
  );

  // Next-state and output decode; play=0 freezes every state except SONG_DONE
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    dur_d     = dur_q;
    load_d    = 1'b0;
    acc_clr_s = 1'b0;
    acc_wr_s  = 1'b0;
    end_hit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d   = S_FETCH;
          base_d    = sel_base_s;
          addr_d    = sel_base_s;
          acc_clr_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (play) state_d = S_ROM_WAIT; else state_d = S_FETCH;
      end
      S_ROM_WAIT: begin
        if (play) state_d = S_DECODE; else state_d = S_ROM_WAIT;
      end
      S_DECODE: begin
        if (!play) begin
          state_d = S_DECODE;
        end else if (sif.rom_data == END_MARKER) begin
          end_hit_s = 1'b1;
        end else if (sif.rom_data[ADV_BIT]) begin
          dur_d   = entry_dur(sif.rom_data);
          state_d = S_LOAD;
        end else begin
          acc_wr_s = 1'b1;
          if (last_s) begin
            end_hit_s = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_FETCH;
          end
        end
      end
      S_LOAD: begin
        // strobe is issued only on an edge where play is high
        if (play) begin
          load_d  = 1'b1;
          state_d = S_GUARD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_GUARD: begin
        if (play) state_d = S_WAIT_DONE; else state_d = S_GUARD;
      end
      S_WAIT_DONE: begin
        if (play && sif.done_with_note) begin
          acc_clr_s = 1'b1;
          if (last_s) begin
            end_hit_s = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_SONG_DONE: begin
        if (restart || (play && !play_prev_q)) begin
          state_d   = S_FETCH;
          base_d    = sel_base_s;
          addr_d    = sel_base_s;
          acc_clr_s = 1'b1;
        end else begin
          state_d = S_SONG_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_hit_s) begin
`ifdef LOOP_EN
      state_d   = S_FETCH;
      addr_d    = base_q;
      acc_clr_s = 1'b1;
`else
      state_d   = S_SONG_DONE;
`endif
    end else begin
      end_hit_s = 1'b0;
    end

    if (restart && (state_q != S_IDLE) && (state_q != S_SONG_DONE)) begin
      state_d   = S_FETCH;
      addr_d    = base_q;
      acc_clr_s = 1'b1;
      acc_wr_s  = 1'b0;
      load_d    = 1'b0;
      end_hit_s = 1'b0;
    end else begin
      end_hit_s = end_hit_s;
    end

`ifdef LOOP_EN
    song_done_d = end_hit_s;
`else
    song_done_d = (state_d == S_SONG_DONE);
`endif
    play_enable_d = play && ((state_d == S_LOAD) || (state_d == S_GUARD) ||
                             (state_d == S_WAIT_DONE));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      base_q        <= {ADDR_WIDTH{1'b0}};
      dur_q         <= 6'd0;
      load_q        <= 1'b0;
      play_enable_q <= 1'b0;
      song_done_q   <= 1'b0;
      play_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      dur_q         <= dur_d;
      load_q        <= load_d;
      play_enable_q <= play_enable_d;
      song_done_q   <= song_done_d;
      play_prev_q   <= play;
    end
  end

  assign sif.rom_addr      = addr_q;
  assign sif.note1         = notes_s[0];
  assign sif.note2         = notes_s[1];
  assign sif.note3         = notes_s[2];
  assign sif.note4         = notes_s[3];
  assign sif.metadata1     = metas_s[0];
  assign sif.metadata2     = metas_s[1];
  assign sif.metadata3     = metas_s[2];
  assign sif.metadata4     = metas_s[3];
  assign sif.num_notes     = num_notes_s;
  assign sif.duration      = dur_q;
  assign sif.load_new_note = load_q;
  assign sif.play_enable   = play_enable_q;
  assign song_done         = song_done_q;

endmodule

// File: doc/chord_scheduler.md
Name: chord_scheduler

Overview:
- Sequences a song for the four-voice notes player.
- Fetches 16-bit entries from a synchronous song ROM and accumulates up to 4 note entries into one chord.
- On an advance entry, loads the chord (notes, metadata, voice count, duration) into the notes player with a one-cycle load_new_note pulse, then waits for done_with_note before fetching again.
- Sits between the song ROM and the notes player, in place of a single-note song reader.

Parameters:
- ADDR_WIDTH, 7, song ROM address width.
- SONG_SEL_WIDTH, 2, song select width; song base address = song_sel << (ADDR_WIDTH-SONG_SEL_WIDTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- play  input  1  level; high = run/play, low = pause.
- song_sel  input  SONG_SEL_WIDTH  song choice; sampled only when leaving IDLE or SONG_DONE.
- restart  input  1  pulse; return to the current song base address and clear the chord.
- rom_addr  output  ADDR_WIDTH  song ROM address.
- rom_data  input  16  ROM data, valid 1 cycle after rom_addr.
- note1..note4  output  6 each  chord notes; unused slots are 0.
- metadata1..metadata4  output  3 each  per-note metadata; unused slots are 0.
- num_notes  output  2  voice count minus 1.
- duration  output  6  chord duration in 1/48 s beats.
- load_new_note  output  1  one-cycle load strobe.
- play_enable  output  1  forwarded to the notes player.
- done_with_note  input  1  from the notes player.
- song_done  output  1  level; high at end of song.

Behaviour:
- Entry format:
  - bit15=0: note entry; [14:9] note, [8:3] unused, [2:0] metadata.
  - bit15=1: advance entry; [8:3] duration, other bits ignored.
  - 16'h0000: end marker.
- Reset (reset=0, asynchronous):
  - state=IDLE; rom_addr=0; all notes, metadata, num_notes and duration = 0.
  - load_new_note=0, play_enable=0, song_done=0; chord count=0.
- IDLE -> FETCH when play=1; rom_addr <= song base.
- FETCH: drive rom_addr -> ROM_WAIT, 1 cycle.
- ROM_WAIT -> DECODE, next cycle.
- DECODE:
  - Note entry: if chord count<4, write the note into slot count+1 and increment count. If count=4, drop the entry (5th+ notes ignored). Increment rom_addr, go to FETCH.
  - Advance entry: latch duration, go to LOAD.
  - End marker: go to SONG_DONE.
- LOAD:
  - Pulse load_new_note for exactly 1 cycle.
  - num_notes = count-1, or 0 if count=0. Count 0 is a rest: note1=0, num_notes=0.
  - Go to GUARD.
- GUARD: 1 cycle; done_with_note ignored, covering the stale done from the previous note. Go to WAIT_DONE.
- WAIT_DONE:
  - When done_with_note=1: clear the chord (count=0, slots=0), increment rom_addr, go to FETCH.
  - Note/metadata outputs hold stable from LOAD until the exit from WAIT_DONE.
- Address wrap: incrementing from base+2^(ADDR_WIDTH-SONG_SEL_WIDTH)-1 goes to SONG_DONE instead of entering another song region.
- SONG_DONE: song_done=1; play_enable=0.
  - Leave on restart=1, or when play toggles 0->1. Either goes to FETCH at the newly sampled song base, with song_done cleared.
- play_enable = play AND state in {LOAD, GUARD, WAIT_DONE}.
- Pause (play=0):
  - FSM freezes in its current state; no fetch advances.
  - A pending load_new_note is deferred until play=1, so the strobe never fires while paused.
- restart:
  - In any state except IDLE: go to FETCH at the current song base and clear the chord, next cycle.
  - Restart coinciding with done_with_note: restart wins.
- Advance entry with duration 0: LOAD still issues; done is handled by the notes player.

Optional Feature:
- LOOP_EN defined: end marker or address wrap returns to the song base and continues in FETCH; song_done pulses 1 cycle per loop.
- LOOP_EN undefined: behaviour as above; SONG_DONE is terminal until restart or a play re-press.

Decomposition:
- Package chord_sched_pkg:
  - Entry field positions/widths: NOTE_MSB/LSB, DUR_MSB/LSB, META_MSB/LSB, ADV_BIT.
  - END_MARKER = 16'h0000.
  - State encodings IDLE, FETCH, ROM_WAIT, DECODE, LOAD, GUARD, WAIT_DONE, SONG_DONE.
- Sub-module chord_accumulator:
  - Inputs: clear, write strobe, note, metadata.
  - Holds 4 slots plus a 3-bit count; drops writes at count=4.
  - Outputs: slot registers and num_notes.

Test Plan:
- ROM {note 20 m0, note 24 m1, note 27 m0, adv dur 12, 0000}, play=1 -> one load_new_note with note1..3=20/24/27, metadata2=1, num_notes=2, duration=12. Hold done=0 for 50 cycles: outputs stable. Then done=1 -> song_done=1.
- Six note entries then adv dur 6 -> num_notes=3, note4 = 4th entry; entries 5 and 6 are absent from all slots.
- Lone advance entry dur 8 -> load with num_notes=0, note1=0 (rest).
- done_with_note held high from the previous note through LOAD/GUARD -> no early advance; exactly 1 load per chord.
- play dropped in WAIT_DONE for 100 cycles -> play_enable=0, rom_addr unchanged. Drop play in DECODE before an advance -> no load_new_note until play returns.
- Async reset asserted mid-WAIT_DONE (not clock-aligned) -> all outputs 0 immediately. With LOOP_EN, the end marker returns rom_addr to the song base and song_done pulses for 1 cycle.
